// File: rtl/memory_bank_write_sequencer.sv
// -----------------------------------------------------------------------------
// memory_bank_write_sequencer
//
// Purpose:
//   Write-side initiator for a byte-masked 1W memory bank port.
//   After reset, or when init_start is pulsed, it clears every row of the bank
//   with INIT_VALUE. It accepts byte-masked write requests through a
//   valid/ready handshake and buffers them in a small FIFO. A request to the
//   same address as the youngest buffered entry is merged into that entry
//   instead of taking a new slot. Buffered requests are drained to the bank
//   one per cycle, in acceptance order.
//
// Ports:
//   clock              in   single clock
//   resetn             in   asynchronous active-low reset
//   req_valid          in   write request valid
//   req_ready          out  request accepted at the edge when valid && ready
//   req_address        in   target row
//   req_byte_enable    in   lane mask (all-zero requests are accepted, then dropped)
//   req_data           in   write data
//   write_hold         in   freezes FIFO draining (the sweep is not affected)
//   init_start         in   single-cycle pulse that restarts the clearing sweep
//   init_busy          out  sweep in progress
//   idle               out  sweep not running and FIFO empty
//   bank_write_enable  out  bank lane write enables
//   bank_write_address out  bank write row
//   bank_write_data    out  bank write data
// -----------------------------------------------------------------------------
module memory_bank_write_sequencer #(
   parameter int                              SIZE       = 1024,
   parameter int                              ADDR_WIDTH = $clog2(SIZE),
   parameter int                              COL_WIDTH  = 8,
   parameter int                              NB_COL     = 4,
   parameter int                              FIFO_DEPTH = 4,
   parameter logic [NB_COL*COL_WIDTH-1:0]     INIT_VALUE = '0
) (
   input  logic                        clock,
   input  logic                        resetn,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [ADDR_WIDTH-1:0]       req_address,
   input  logic [NB_COL-1:0]           req_byte_enable,
   input  logic [NB_COL*COL_WIDTH-1:0] req_data,
   input  logic                        write_hold,
   input  logic                        init_start,
   output logic                        init_busy,
   output logic                        idle,
   output logic [NB_COL-1:0]           bank_write_enable,
   output logic [ADDR_WIDTH-1:0]       bank_write_address,
   output logic [NB_COL*COL_WIDTH-1:0] bank_write_data
);

   localparam int DATA_W = NB_COL * COL_WIDTH;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  sweep_cnt_q, sweep_cnt_d;

   // FIFO storage and bookkeeping
   logic [ADDR_WIDTH-1:0]  fifo_addr_q [FIFO_DEPTH];
   logic [NB_COL-1:0]      fifo_be_q   [FIFO_DEPTH];
   logic [DATA_W-1:0]      fifo_data_q [FIFO_DEPTH];
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;

   // Last values driven onto the bank port, held while no write is issued
   logic [ADDR_WIDTH-1:0]  last_addr_q;
   logic [DATA_W-1:0]      last_data_q;

   // ---------------------------------------------------------------------
   // Combinational control
   // ---------------------------------------------------------------------
   logic                   sweep_last;
   logic                   pop;
   logic                   full;
   logic [PTR_W-1:0]       tail_ptr;
   logic                   tail_popped;
   logic                   merge_hit;
   logic                   accept;
   logic                   push;
   logic                   merge;
   logic [DATA_W-1:0]      merged_data;

   logic                   drive_valid;
   logic [NB_COL-1:0]      drive_be;
   logic [ADDR_WIDTH-1:0]  drive_addr;
   logic [DATA_W-1:0]      drive_data;

   assign sweep_last  = (sweep_cnt_q == ADDR_WIDTH'(SIZE - 1));
   assign full        = (count_q == CNT_W'(FIFO_DEPTH));
   assign tail_ptr    = wr_ptr_q - PTR_W'(1);

   // The tail is only popped when it is also the head, i.e. a single entry.
   assign tail_popped = pop && (count_q == CNT_W'(1));
   assign merge_hit   = (count_q != '0) &&
                        (fifo_addr_q[tail_ptr] == req_address) &&
                        !tail_popped;

   // A pop does not free a slot for the request presented in the same cycle.
   assign req_ready   = resetn && (!full || merge_hit);
   assign accept      = req_valid && req_ready;

   // All-zero masks are accepted but never stored.
   assign push        = accept && (req_byte_enable != '0) && !merge_hit;
   assign merge       = accept && (req_byte_enable != '0) && merge_hit;

   // Per-lane merge: enabled request lanes replace the stored tail lanes.
   generate
      for (genvar gi = 0; gi < NB_COL; gi++) begin : g_merge_lane
         assign merged_data[gi*COL_WIDTH +: COL_WIDTH] =
            req_byte_enable[gi] ? req_data[gi*COL_WIDTH +: COL_WIDTH]
                                : fifo_data_q[tail_ptr][gi*COL_WIDTH +: COL_WIDTH];
      end
   endgenerate

   // ---------------------------------------------------------------------
   // FSM process 1: state register (sweep counter travels with the state)
   // ---------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_INIT;
         sweep_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         sweep_cnt_q <= sweep_cnt_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM process 2: next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      sweep_cnt_d = sweep_cnt_q;
      case (state_q)
         ST_INIT: begin
            // init_start is deliberately ignored while sweeping.
            if (sweep_last) begin
               state_d     = ST_RUN;
               sweep_cnt_d = '0;
            end else begin
               sweep_cnt_d = sweep_cnt_q + ADDR_WIDTH'(1);
            end
         end
         ST_RUN: begin
            if (init_start) begin
               state_d     = ST_INIT;
               sweep_cnt_d = '0;
            end
         end
         default: begin
            state_d     = ST_INIT;
            sweep_cnt_d = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM process 3: outputs and bank port selection
   // ---------------------------------------------------------------------
   always_comb begin
      pop         = (state_q == ST_RUN) && !write_hold && (count_q != '0);
      init_busy   = (state_q == ST_INIT);
      idle        = (state_q == ST_RUN) && (count_q == '0);
      drive_valid = 1'b0;
      drive_be    = '0;
      drive_addr  = last_addr_q;
      drive_data  = last_data_q;
      if (state_q == ST_INIT) begin
         drive_valid = 1'b1;
         drive_be    = '1;
         drive_addr  = sweep_cnt_q;
         drive_data  = INIT_VALUE;
      end else if (pop) begin
         drive_valid = 1'b1;
         drive_be    = fifo_be_q[rd_ptr_q];
         drive_addr  = fifo_addr_q[rd_ptr_q];
         drive_data  = fifo_data_q[rd_ptr_q];
      end
   end

   // While reset is low the port shows the cleared holding registers and
   // no lane is enabled, regardless of the clock.
   assign bank_write_enable  = resetn ? drive_be   : '0;
   assign bank_write_address = resetn ? drive_addr : last_addr_q;
   assign bank_write_data    = resetn ? drive_data : last_data_q;

   // ---------------------------------------------------------------------
   // FIFO pointers, occupancy and held port values
   // ---------------------------------------------------------------------
   always_comb begin
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         last_addr_q <= '0;
         last_data_q <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (drive_valid) begin
            last_addr_q <= drive_addr;
            last_data_q <= drive_data;
         end
      end
   end

   // Entry storage needs no reset: occupancy alone decides validity.
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= req_address;
         fifo_be_q[wr_ptr_q]   <= req_byte_enable;
         fifo_data_q[wr_ptr_q] <= req_data;
      end else if (merge) begin
         fifo_be_q[tail_ptr]   <= fifo_be_q[tail_ptr] | req_byte_enable;
         fifo_data_q[tail_ptr] <= merged_data;
      end
   end

endmodule

// File: tb/tb_memory_bank_write_sequencer.sv
// -----------------------------------------------------------------------------
// Directed testbench for memory_bank_write_sequencer (SIZE=16, FIFO_DEPTH=4).
// Inputs change just after the falling edge; outputs are checked 1ns later,
// well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_memory_bank_write_sequencer;

   localparam int          SIZE = 16;
   localparam int          AW   = 4;
   localparam int          NBC  = 4;
   localparam int          CW   = 8;
   localparam int          DW   = NBC * CW;
   localparam int          FD   = 4;
   localparam logic [31:0] INIT = 32'hDEAD_BEEF;

   logic          clock = 1'b0;
   logic          resetn = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_address = '0;
   logic [3:0]    req_byte_enable = '0;
   logic [DW-1:0] req_data = '0;
   logic          write_hold = 1'b0;
   logic          init_start = 1'b0;
   logic          init_busy;
   logic          idle;
   logic [3:0]    bank_write_enable;
   logic [AW-1:0] bank_write_address;
   logic [DW-1:0] bank_write_data;

   int n_tests = 0;
   int n_fail  = 0;

   memory_bank_write_sequencer #(
      .SIZE       (SIZE),
      .ADDR_WIDTH (AW),
      .COL_WIDTH  (CW),
      .NB_COL     (NBC),
      .FIFO_DEPTH (FD),
      .INIT_VALUE (INIT)
   ) dut (
      .clock              (clock),
      .resetn             (resetn),
      .req_valid          (req_valid),
      .req_ready          (req_ready),
      .req_address        (req_address),
      .req_byte_enable    (req_byte_enable),
      .req_data           (req_data),
      .write_hold         (write_hold),
      .init_start         (init_start),
      .init_busy          (init_busy),
      .idle               (idle),
      .bank_write_enable  (bank_write_enable),
      .bank_write_address (bank_write_address),
      .bank_write_data    (bank_write_data)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(negedge clock);
   endtask

   task automatic drive(input logic v, input logic [AW-1:0] a,
                        input logic [3:0] be, input logic [DW-1:0] d);
      req_valid       = v;
      req_address     = a;
      req_byte_enable = be;
      req_data        = d;
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      resetn = 1'b0;
      drive(1'b1, 4'd3, 4'hF, 32'h1234_5678);
      repeat (3) step();
      #1;
      n_tests++;
      if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready); end
      n_tests++;
      if ({init_busy, idle} !== 2'b10) begin n_fail++; $display("FAIL reset_status: busy=%b idle=%b want busy=1 idle=0", init_busy, idle); end
      n_tests++;
      if ({bank_write_enable, bank_write_address, bank_write_data} !== {4'h0, 4'h0, 32'h0}) begin
         n_fail++;
         $display("FAIL reset_port: be=%h addr=%0d data=%h want be=0 addr=0 data=0", bank_write_enable, bank_write_address, bank_write_data);
      end
      drive(1'b0, 4'd0, 4'h0, 32'h0);
      resetn = 1'b1;
      #1;
      n_tests++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b want 1", req_ready); end
   endtask

   // ------------------------------------------------------------------
   task automatic test_sweep();
      for (int r = 0; r < SIZE; r++) begin
         #1;
         n_tests++;
         if ({bank_write_enable, bank_write_address, bank_write_data, init_busy} !== {4'hF, 4'(r), INIT, 1'b1}) begin
            n_fail++;
            $display("FAIL sweep_row%0d: be=%h addr=%0d data=%h busy=%b want be=f addr=%0d data=%h busy=1", r, bank_write_enable, bank_write_address, bank_write_data, init_busy, r, INIT);
         end
         step();
      end
      for (int c = 0; c < 2; c++) begin
         #1;
         n_tests++;
         if ({init_busy, idle, bank_write_enable} !== {1'b0, 1'b1, 4'h0}) begin
            n_fail++;
            $display("FAIL sweep_done%0d: busy=%b idle=%b be=%h want busy=0 idle=1 be=0", c, init_busy, idle, bank_write_enable);
         end
         step();
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_push_during_sweep();
      logic [AW-1:0] exp_a [5];
      exp_a = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7};
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      for (int r = 0; r < SIZE; r++) begin
         if (r < 4) drive(1'b1, 4'(r + 1), 4'hF, 32'hA000_0000 | 32'(r + 1));
         else       drive(1'b1, 4'd7, 4'hF, 32'hA000_0007);
         #1;
         n_tests++;
         if ({bank_write_enable, bank_write_address, bank_write_data} !== {4'hF, 4'(r), INIT}) begin
            n_fail++;
            $display("FAIL fill_sweep_row%0d: be=%h addr=%0d data=%h want be=f addr=%0d data=%h", r, bank_write_enable, bank_write_address, bank_write_data, r, INIT);
         end
         n_tests++;
         if (req_ready !== (r < 4)) begin
            n_fail++;
            $display("FAIL fill_ready_row%0d: got %b want %b", r, req_ready, (r < 4));
         end
         step();
      end
      for (int i = 0; i < 5; i++) begin
         #1;
         n_tests++;
         if ({bank_write_enable, bank_write_address, bank_write_data} !== {4'hF, exp_a[i], 32'hA000_0000 | 32'(exp_a[i])}) begin
            n_fail++;
            $display("FAIL drain%0d: be=%h addr=%0d data=%h want be=f addr=%0d", i, bank_write_enable, bank_write_address, bank_write_data, exp_a[i]);
         end
         if (i < 2) begin
            n_tests++;
            if (req_ready !== (i == 1)) begin
               n_fail++;
               $display("FAIL drain_ready%0d: got %b want %b", i, req_ready, (i == 1));
            end
         end
         step();
         if (i == 1) drive(1'b0, 4'd0, 4'h0, 32'h0);
      end
      #1;
      n_tests++;
      if ({bank_write_enable, idle} !== {4'h0, 1'b1}) begin
         n_fail++;
         $display("FAIL drain_end: be=%h idle=%b want be=0 idle=1", bank_write_enable, idle);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_merge();
      step();
      write_hold = 1'b1;
      drive(1'b1, 4'd5, 4'b0011, 32'h0000_BBAA);
      #1;
      n_tests++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL merge_ready0: got %b want 1", req_ready); end
      step();
      drive(1'b1, 4'd5, 4'b0110, 32'h00CC_DD00);
      #1;
      n_tests++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL merge_ready1: got %b want 1", req_ready); end
      step();
      drive(1'b0, 4'd0, 4'h0, 32'h0);
      #1;
      n_tests++;
      if ({bank_write_enable, bank_write_address, bank_write_data, idle} !== {4'h0, 4'd7, 32'hA000_0007, 1'b0}) begin
         n_fail++;
         $display("FAIL merge_hold: be=%h addr=%0d data=%h idle=%b want be=0 addr=7 data=a0000007 idle=0", bank_write_enable, bank_write_address, bank_write_data, idle);
      end
      step();
      write_hold = 1'b0;
      #1;
      n_tests++;
      if ({bank_write_enable, bank_write_address, bank_write_data} !== {4'b0111, 4'd5, 32'h00CC_DDAA}) begin
         n_fail++;
         $display("FAIL merge_write: be=%h addr=%0d data=%h want be=7 addr=5 data=00ccddaa", bank_write_enable, bank_write_address, bank_write_data);
      end
      step();
      #1;
      n_tests++;
      if ({bank_write_enable, idle, bank_write_address, bank_write_data} !== {4'h0, 1'b1, 4'd5, 32'h00CC_DDAA}) begin
         n_fail++;
         $display("FAIL merge_single: be=%h idle=%b addr=%0d data=%h want be=0 idle=1 addr=5 data=00ccddaa", bank_write_enable, idle, bank_write_address, bank_write_data);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_full_merge();
      logic [AW-1:0] a  [4];
      logic [3:0]    be [4];
      logic [DW-1:0] d  [4];
      logic [3:0]    ebe [4];
      logic [DW-1:0] ed  [4];
      a   = '{4'd6, 4'd8, 4'd11, 4'd9};
      be  = '{4'hF, 4'hF, 4'hF, 4'b0001};
      d   = '{32'h6666_6666, 32'h8888_8888, 32'hBBBB_BBBB, 32'h0000_0099};
      ebe = '{4'hF, 4'hF, 4'hF, 4'b1001};
      ed  = '{32'h6666_6666, 32'h8888_8888, 32'hBBBB_BBBB, 32'h7700_0099};
      step();
      write_hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, a[i], be[i], d[i]);
         #1;
         n_tests++;
         if (req_ready !== 1'b1) begin n_fail++; $display("FAIL full_fill%0d: ready=%b want 1", i, req_ready); end
         step();
      end
      drive(1'b1, 4'd9, 4'b1000, 32'h7700_0000);
      #1;
      n_tests++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL full_merge_ready: got %b want 1", req_ready); end
      step();
      drive(1'b1, 4'd10, 4'hF, 32'h1010_1010);
      #1;
      n_tests++;
      if (req_ready !== 1'b0) begin n_fail++; $display("FAIL full_other_ready: got %b want 0", req_ready); end
      step();
      drive(1'b1, 4'd12, 4'h0, 32'h1212_1212);
      #1;
      n_tests++;
      if (req_ready !== 1'b0) begin n_fail++; $display("FAIL full_be0_ready: got %b want 0", req_ready); end
      step();
      drive(1'b0, 4'd0, 4'h0, 32'h0);
      write_hold = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_tests++;
         if ({bank_write_enable, bank_write_address, bank_write_data} !== {ebe[i], a[i], ed[i]}) begin
            n_fail++;
            $display("FAIL full_drain%0d: be=%h addr=%0d data=%h want be=%h addr=%0d data=%h", i, bank_write_enable, bank_write_address, bank_write_data, ebe[i], a[i], ed[i]);
         end
         step();
      end
      #1;
      n_tests++;
      if ({bank_write_enable, idle} !== {4'h0, 1'b1}) begin n_fail++; $display("FAIL full_drain_end: be=%h idle=%b want be=0 idle=1", bank_write_enable, idle); end
      drive(1'b1, 4'd13, 4'h0, 32'h1313_1313);
      #1;
      n_tests++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL be0_ready: got %b want 1", req_ready); end
      step();
      drive(1'b0, 4'd0, 4'h0, 32'h0);
      for (int c = 0; c < 2; c++) begin
         #1;
         n_tests++;
         if ({bank_write_enable, idle} !== {4'h0, 1'b1}) begin n_fail++; $display("FAIL be0_discard%0d: be=%h idle=%b want be=0 idle=1", c, bank_write_enable, idle); end
         step();
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_init_restart();
      write_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'(i + 2), 4'hF, 32'hC000_0000 | 32'(i + 2));
         step();
      end
      drive(1'b0, 4'd0, 4'h0, 32'h0);
      init_start = 1'b1;
      #1;
      n_tests++;
      if ({bank_write_enable, init_busy} !== {4'h0, 1'b0}) begin n_fail++; $display("FAIL restart_held: be=%h busy=%b want be=0 busy=0", bank_write_enable, init_busy); end
      step();
      init_start = 1'b0;
      write_hold = 1'b0;
      for (int r = 0; r < SIZE; r++) begin
         init_start = (r == 5);
         #1;
         n_tests++;
         if ({bank_write_enable, bank_write_address, bank_write_data, init_busy} !== {4'hF, 4'(r), INIT, 1'b1}) begin
            n_fail++;
            $display("FAIL restart_row%0d: be=%h addr=%0d data=%h busy=%b want be=f addr=%0d data=%h busy=1", r, bank_write_enable, bank_write_address, bank_write_data, init_busy, r, INIT);
         end
         step();
      end
      init_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++;
         if ({bank_write_enable, bank_write_address, bank_write_data} !== {4'hF, 4'(i + 2), 32'hC000_0000 | 32'(i + 2)}) begin
            n_fail++;
            $display("FAIL restart_drain%0d: be=%h addr=%0d data=%h want be=f addr=%0d", i, bank_write_enable, bank_write_address, bank_write_data, i + 2);
         end
         step();
      end
      #1;
      n_tests++;
      if ({bank_write_enable, idle} !== {4'h0, 1'b1}) begin n_fail++; $display("FAIL restart_end: be=%h idle=%b want be=0 idle=1", bank_write_enable, idle); end
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset_mid_drain();
      logic [AW-1:0] a [3];
      a = '{4'd14, 4'd15, 4'd1};
      step();
      write_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, a[i], 4'hF, 32'hE000_0000 | 32'(a[i]));
         step();
      end
      drive(1'b0, 4'd0, 4'h0, 32'h0);
      write_hold = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_tests++;
         if ({bank_write_enable, bank_write_address} !== {4'hF, a[i]}) begin
            n_fail++;
            $display("FAIL abort_drain%0d: be=%h addr=%0d want be=f addr=%0d", i, bank_write_enable, bank_write_address, a[i]);
         end
         if (i == 0) step();
      end
      resetn = 1'b0;
      #1;
      n_tests++;
      if ({bank_write_enable, bank_write_address, req_ready, init_busy} !== {4'h0, 4'd0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL abort_reset: be=%h addr=%0d ready=%b busy=%b want be=0 addr=0 ready=0 busy=1", bank_write_enable, bank_write_address, req_ready, init_busy);
      end
      step();
      resetn = 1'b1;
      for (int r = 0; r < SIZE; r++) begin
         #1;
         n_tests++;
         if ({bank_write_enable, bank_write_address, bank_write_data} !== {4'hF, 4'(r), INIT}) begin
            n_fail++;
            $display("FAIL abort_sweep_row%0d: be=%h addr=%0d data=%h want be=f addr=%0d data=%h", r, bank_write_enable, bank_write_address, bank_write_data, r, INIT);
         end
         step();
      end
      for (int c = 0; c < 4; c++) begin
         #1;
         n_tests++;
         if ({bank_write_enable, idle} !== {4'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL abort_no_stale%0d: be=%h addr=%0d idle=%b want be=0 idle=1", c, bank_write_enable, bank_write_address, idle);
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_push_during_sweep();
      test_merge();
      test_full_merge();
      test_init_restart();
      test_reset_mid_drain();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/memory_bank_write_sequencer.md
# memory_bank_write_sequencer

Write-side initiator for the byte-masked 1W port of the asynchronous-read register/memory banks. It clears the whole bank with an initialisation sweep after reset or on command. It then accepts byte-masked write requests through a valid/ready handshake and buffers them in a small FIFO that merges same-address writes. Buffered requests are issued to the bank's write port one per cycle. It sits between pipeline writeback logic and the bank instance, so producers never need to track bank initialisation or hold periods.

## Interface
- SIZE, 1024: bank depth in rows.
- ADDR_WIDTH, $clog2(SIZE): row address width.
- COL_WIDTH, 8: bits per byte lane.
- NB_COL, 4: byte lanes per row.
- FIFO_DEPTH, 4: buffered request entries; a power of two, ≥2.
- INIT_VALUE, 0: NB_COL*COL_WIDTH-bit value written to every row by the sweep.
- clock  in  1  single clock for the block.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  write request valid.
- req_ready  out  1  request accepted at a rising edge when req_valid && req_ready.
- req_address  in  ADDR_WIDTH  target row.
- req_byte_enable  in  NB_COL  lane mask.
- req_data  in  NB_COL*COL_WIDTH  write data.
- write_hold  in  1  freezes FIFO draining; does not affect the sweep.
- init_start  in  1  single-cycle pulse that re-runs the sweep.
- init_busy  out  1  sweep in progress.
- idle  out  1  sweep not running and FIFO empty.
- bank_write_enable  out  NB_COL  connects to the bank write_enable.
- bank_write_address  out  ADDR_WIDTH  connects to the bank write_address.
- bank_write_data  out  NB_COL*COL_WIDTH  connects to the bank write_data.

## Operation
- Two states: INIT and RUN. Reset enters INIT with sweep counter 0 and an empty FIFO.
- INIT:
  - Bank port carries address = counter, enable = all ones, data = INIT_VALUE.
  - Counter increments every cycle.
  - In the cycle the counter equals SIZE-1, that row is written and the state moves to RUN at the edge.
  - init_start is ignored while in INIT.
  - The FIFO keeps accepting requests but does not drain.
- RUN:
  - If the FIFO is non-empty and write_hold=0, the head entry drives the bank port and is popped at the same edge.
  - Otherwise bank_write_enable=0. Address and data then keep their last driven values.
  - init_start=1 moves the state to INIT with counter 0 at the next edge. FIFO contents are preserved and drain after the sweep.
- Acceptance: req_ready = !full || merge_hit. `full` is the registered count == FIFO_DEPTH. A pop in the same cycle does not free a slot for that cycle's request.
- Merge:
  - merge_hit is true when count ≥ 1, the tail entry address == req_address, and the tail entry is not being popped this cycle.
  - On a hit, the request is written into the tail entry: each enabled lane's data overwrites the stored lane, and the stored mask becomes tail mask | req mask. No new entry is allocated.
  - Merging is allowed even when the FIFO is full.
- A request with req_byte_enable == 0 is accepted (req_ready follows the normal rule) and discarded; it allocates no entry.
- Ordering: writes reach the bank in acceptance order. Merging never reorders distinct addresses.
- Outputs:
  - init_busy = (state == INIT).
  - idle = (state == RUN) && (count == 0).
- resetn low:
  - bank_write_enable is forced to 0 combinationally.
  - FIFO cleared, state INIT, counter 0, req_ready=0.

## Timing
- Reset values: req_ready=0, init_busy=1, idle=0, bank_write_enable=0, bank_write_address=0, bank_write_data=0.
- First cycle after reset release: sweep row 0 is on the bank port and req_ready = !full (=1).
- Sweep length: exactly SIZE cycles. init_busy falls after the edge that writes row SIZE-1.
- Request latency (RUN, write_hold=0): accepted at edge N, visible on the bank port during cycle N→N+1, written into the bank at edge N+1.
- Throughput: one accept and one bank write per cycle.
- Count update: count' = count + push − pop. A merge does not count as a push.
- Reset asserted mid-sweep or mid-drain aborts everything: pending FIFO entries are lost and the sweep restarts from row 0 after release.

## Test plan
- SIZE=16, FIFO_DEPTH=4, release reset:
  - Rows 0..15 are written with enable 4'hF and data INIT_VALUE on 16 consecutive cycles.
  - init_busy=0 and idle=1 from the following cycle.
- During the sweep, push writes to addresses 1, 2, 3, 4:
  - A 5th push to address 7 sees req_ready=0.
  - After the sweep, the bank sees 1, 2, 3, 4 on consecutive cycles.
  - The push to address 7 is accepted after the first pop and written next.
- write_hold=1; push addr 5, be 0011, data 0x0000BBAA; then push addr 5, be 0110, data 0x00CCDD00:
  - The FIFO holds one entry.
  - After write_hold=0, a single write: addr 5, be 0111, data 0x00CCDDAA.
- write_hold=1, FIFO full with tail address 9:
  - A push to address 9 is accepted (merge).
  - A push to address 10 sees req_ready=0.
  - A push with be=0 is accepted only when not full, and never appears on the bank port.
- RUN with 3 entries held; pulse init_start:
  - The sweep covers all 16 rows.
  - The 3 entries are written in order afterwards.
  - An init_start pulse during the sweep has no effect.
- Assert resetn low while 2 entries are draining:
  - bank_write_enable=0 immediately.
  - After release, only sweep writes appear and the old entries are never written.
